// File: rtl/calc_controller.sv
// ---------------------------------------------------------------------------
// calc_controller
//   Keypad calculator sequencer. Collects two decimal operands (0-99) and an
//   operator from keypad strobes, launches an external ALU, waits for its
//   result and drives the display select and status LEDs.
//
// Ports
//   clk         in   system clock, rising edge
//   nrst        in   asynchronous active-low reset
//   num_strobe  in   digit key pulse, value on num_val (10-15 illegal)
//   num_val     in   [3:0] digit value
//   op_strobe   in   operator key pulse, code on op_sel
//   op_sel      in   [1:0] 0 add, 1 sub, 2 mul, 3 reserved (error)
//   eq_strobe   in   equals key pulse
//   clr_strobe  in   clear key pulse (highest priority)
//   alu_done    in   ALU result-ready pulse
//   alu_err     in   ALU overflow/underflow, qualified by alu_done
//   opnd_a      out  [6:0] operand A
//   opnd_b      out  [6:0] operand B
//   op          out  [1:0] operator code
//   alu_start   out  one-cycle ALU start pulse
//   disp_sel    out  [1:0] 0 = A, 1 = B, 2 = result, 3 = blank
//   busy        out  waiting on the ALU
//   red         out  error indicator
//   blue        out  result-valid indicator
//
// Build option
//   CALC_ALU_TIMEOUT_EN : when defined, WAIT_ALU gives up after 20 cycles
//                         without alu_done and enters ERR.
// ---------------------------------------------------------------------------
module calc_controller (
    input  logic       clk,
    input  logic       nrst,
    input  logic       num_strobe,
    input  logic [3:0] num_val,
    input  logic       op_strobe,
    input  logic [1:0] op_sel,
    input  logic       eq_strobe,
    input  logic       clr_strobe,
    input  logic       alu_done,
    input  logic       alu_err,
    output logic [6:0] opnd_a,
    output logic [6:0] opnd_b,
    output logic [1:0] op,
    output logic       alu_start,
    output logic [1:0] disp_sel,
    output logic       busy,
    output logic       red,
    output logic       blue
);

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        WAIT_ALU = 3'd2,
        SHOW     = 3'd3,
        ERR      = 3'd4
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [6:0] a_nxt;
    logic [6:0] b_nxt;
    logic [1:0] op_nxt;
    logic       start_nxt;
    logic       digit_ok;

`ifdef CALC_ALU_TIMEOUT_EN
    logic [4:0] cnt;
    logic [4:0] cnt_nxt;
`endif

    // Shift a new digit in only while the operand is still a single digit,
    // so the third and later digits are dropped and the value stays <= 99.
    function automatic logic [6:0] append_digit(input logic [6:0] cur,
                                                input logic [3:0] d);
        if (cur < 7'd10)
            return 7'(cur * 7'd10 + {3'b000, d});
        else
            return cur;
    endfunction

    function automatic logic [1:0] disp_code(input state_t s);
        case (s)
            ENTER_A:  return 2'd0;
            ENTER_B:  return 2'd1;
            WAIT_ALU: return 2'd1;  // keep B on the display while computing
            SHOW:     return 2'd2;
            default:  return 2'd3;
        endcase
    endfunction

    assign digit_ok = (num_val <= 4'd9);

    // Next-state logic; only the highest-priority strobe (clr > eq > op > num)
    // is considered, even when that strobe has no effect in the current state.
    always_comb begin
        nxt       = state;
        a_nxt     = opnd_a;
        b_nxt     = opnd_b;
        op_nxt    = op;
        start_nxt = 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
        cnt_nxt   = cnt;
`endif
        if (clr_strobe) begin
            // Also swallows any alu_done arriving in the same cycle.
            nxt    = ENTER_A;
            a_nxt  = 7'd0;
            b_nxt  = 7'd0;
            op_nxt = 2'd0;
`ifdef CALC_ALU_TIMEOUT_EN
            cnt_nxt = 5'd0;
`endif
        end else begin
            case (state)
                ENTER_A: begin
                    if (eq_strobe) begin
                        // nothing to compute yet
                    end else if (op_strobe) begin
                        if (op_sel == 2'd3) begin
                            nxt = ERR;
                        end else begin
                            op_nxt = op_sel;
                            b_nxt  = 7'd0;
                            nxt    = ENTER_B;
                        end
                    end else if (num_strobe) begin
                        if (!digit_ok) nxt = ERR;
                        else           a_nxt = append_digit(opnd_a, num_val);
                    end
                end
                ENTER_B: begin
                    if (eq_strobe) begin
                        start_nxt = 1'b1;
                        nxt       = WAIT_ALU;
`ifdef CALC_ALU_TIMEOUT_EN
                        cnt_nxt   = 5'd0;
`endif
                    end else if (op_strobe) begin
                        if (op_sel == 2'd3) nxt = ERR;
                        else                op_nxt = op_sel;
                    end else if (num_strobe) begin
                        if (!digit_ok) nxt = ERR;
                        else           b_nxt = append_digit(opnd_b, num_val);
                    end
                end
                WAIT_ALU: begin
                    if (alu_done) begin
                        nxt = alu_err ? ERR : SHOW;
                    end
`ifdef CALC_ALU_TIMEOUT_EN
                    // cnt counts edges since alu_start; the 20th edge times out.
                    else if (cnt == 5'd19) begin
                        nxt = ERR;
                    end else begin
                        cnt_nxt = cnt + 5'd1;
                    end
`endif
                end
                SHOW: begin
                    if (eq_strobe) begin
                        // result already shown
                    end else if (op_strobe) begin
                        // A is left alone: the datapath loads the result into A.
                        if (op_sel == 2'd3) begin
                            nxt = ERR;
                        end else begin
                            op_nxt = op_sel;
                            b_nxt  = 7'd0;
                            nxt    = ENTER_B;
                        end
                    end else if (num_strobe) begin
                        if (!digit_ok) begin
                            nxt = ERR;
                        end else begin
                            a_nxt = {3'b000, num_val};
                            nxt   = ENTER_A;
                        end
                    end
                end
                ERR: begin
                    // held until clear
                end
                default: nxt = ENTER_A;
            endcase
        end
    end

    // State and all outputs registered together; status outputs decode the
    // state being entered so they line up with it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ENTER_A;
            opnd_a    <= 7'd0;
            opnd_b    <= 7'd0;
            op        <= 2'd0;
            alu_start <= 1'b0;
            disp_sel  <= 2'd0;
            busy      <= 1'b0;
            red       <= 1'b0;
            blue      <= 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
            cnt       <= 5'd0;
`endif
        end else begin
            state     <= nxt;
            opnd_a    <= a_nxt;
            opnd_b    <= b_nxt;
            op        <= op_nxt;
            alu_start <= start_nxt;
            disp_sel  <= disp_code(nxt);
            busy      <= (nxt == WAIT_ALU);
            red       <= (nxt == ERR);
            blue      <= (nxt == SHOW);
`ifdef CALC_ALU_TIMEOUT_EN
            cnt       <= cnt_nxt;
`endif
        end
    end

endmodule
